// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter.
// - ALU opcode constants as understood by the external ALU.
// - FSM state encoding used by alu_share_arb.
package alu_share_arb_pkg;

    localparam logic [7:0] ALU_OP_NOP  = 8'h00;
    localparam logic [7:0] ALU_OP_ADD  = 8'h01;
    localparam logic [7:0] ALU_OP_SUB  = 8'h02;
    localparam logic [7:0] ALU_OP_SLL  = 8'h03;
    localparam logic [7:0] ALU_OP_SLT  = 8'h04;
    localparam logic [7:0] ALU_OP_SLTU = 8'h05;
    localparam logic [7:0] ALU_OP_XOR  = 8'h06;
    localparam logic [7:0] ALU_OP_SRL  = 8'h07;
    localparam logic [7:0] ALU_OP_SRA  = 8'h08;
    localparam logic [7:0] ALU_OP_OR   = 8'h09;
    localparam logic [7:0] ALU_OP_AND  = 8'h0a;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bus bundle between two requesters, the arbiter and the external ALU.
// - req<n>_*: request handshake (valid/ready) with opcode and two operands.
// - rsp<n>_*: response handshake (valid/ready) with result.
// - alu_*: operands out to the combinational ALU and its result back.
// master: requester/ALU side. slave: the arbiter.
interface alu_share_arb_if #(
    parameter int unsigned XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [7:0]      req0_op;
    logic [XLEN-1:0] req0_data1;
    logic [XLEN-1:0] req0_data2;
    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_res;

    logic            req1_valid;
    logic            req1_ready;
    logic [7:0]      req1_op;
    logic [XLEN-1:0] req1_data1;
    logic [XLEN-1:0] req1_data2;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_res;

    logic [7:0]      alu_op;
    logic [XLEN-1:0] alu_data1;
    logic [XLEN-1:0] alu_data2;
    logic [XLEN-1:0] alu_res;

    modport master (
        output req0_valid, req0_op, req0_data1, req0_data2, rsp0_ready,
        input  req0_ready, rsp0_valid, rsp0_res,
        output req1_valid, req1_op, req1_data1, req1_data2, rsp1_ready,
        input  req1_ready, rsp1_valid, rsp1_res,
        input  alu_op, alu_data1, alu_data2,
        output alu_res
    );

    modport slave (
        input  req0_valid, req0_op, req0_data1, req0_data2, rsp0_ready,
        output req0_ready, rsp0_valid, rsp0_res,
        input  req1_valid, req1_op, req1_data1, req1_data2, rsp1_ready,
        output req1_ready, rsp1_valid, rsp1_res,
        output alu_op, alu_data1, alu_data2,
        input  alu_res
    );
endinterface

// File: rtl/alu_share_arb_rr_arb2.sv
// Combinational 2-way round-robin grant.
// - req_i: request vector, bit n = requester n.
// - ptr_i: requester that wins when both request.
// - gnt_o: one-hot grant (all zero when nobody requests).
// - id_o:  index of the granted requester (0 when nobody requests).
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       id_o
);
    always_comb begin
        gnt_o = 2'b00;
        id_o  = 1'b0;
        unique case (req_i)
            2'b01: begin
                gnt_o = 2'b01;
                id_o  = 1'b0;
            end
            2'b10: begin
                gnt_o = 2'b10;
                id_o  = 1'b1;
            end
            2'b11: begin
                gnt_o = ptr_i ? 2'b10 : 2'b01;
                id_o  = ptr_i;
            end
            default: begin
                gnt_o = 2'b00;
                id_o  = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters.
// A request is accepted in IDLE, its operands drive the ALU for one EXEC
// cycle, and the result is held in RESP until the owning requester takes it.
// - clk, rst_n: clock and asynchronous active-low reset.
// - bus: request/response handshakes for both ports and the ALU interface.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned RR_INIT = 0,
    parameter int unsigned XLEN    = 32
) (
    input logic            clk,
    input logic            rst_n,
    alu_share_arb_if.slave bus
);
    localparam logic PtrInit = (RR_INIT != 0);

    state_e          state_q, state_d;
    logic            ptr_q;
    logic            owner_q;
    logic [7:0]      op_q;
    logic [XLEN-1:0] data1_q;
    logic [XLEN-1:0] data2_q;
    logic [XLEN-1:0] res_q;

    logic [1:0]      gnt;
    logic            win_id;
    logic            grant;
    logic            owner_rsp_ready;
    logic            rsp_fire;

    rr_arb2 u_arb (
        .req_i ({bus.req1_valid, bus.req0_valid}),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .id_o  (win_id)
    );

    // Ready is combinational, so mask it while reset is held to keep outputs quiet.
    assign grant           = rst_n && (state_q == StIdle) && (gnt != 2'b00);
    assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    assign rsp_fire        = (state_q == StResp) && owner_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (owner_rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= PtrInit;
            owner_q <= 1'b0;
            op_q    <= ALU_OP_NOP;
            data1_q <= '0;
            data2_q <= '0;
            res_q   <= '0;
        end else begin
            if (grant) begin
                owner_q <= win_id;
                op_q    <= win_id ? bus.req1_op    : bus.req0_op;
                data1_q <= win_id ? bus.req1_data1 : bus.req0_data1;
                data2_q <= win_id ? bus.req1_data2 : bus.req0_data2;
            end
            if (state_q == StExec) begin
                res_q <= bus.alu_res;
            end
            // Hand priority to the other side once this owner is served.
            if (rsp_fire) begin
                ptr_q <= ~owner_q;
            end
        end
    end

    always_comb begin
        bus.req0_ready = grant && gnt[0];
        bus.req1_ready = grant && gnt[1];
        bus.alu_op     = ALU_OP_NOP;
        bus.alu_data1  = '0;
        bus.alu_data2  = '0;
        if (state_q == StExec) begin
            bus.alu_op    = op_q;
            bus.alu_data1 = data1_q;
            bus.alu_data2 = data2_q;
        end
        bus.rsp0_valid = (state_q == StResp) && !owner_q;
        bus.rsp1_valid = (state_q == StResp) && owner_q;
        bus.rsp0_res   = res_q;
        bus.rsp1_res   = res_q;
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a transaction model.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RR_INIT = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arb_if #(.XLEN(XLEN)) bus ();

    alu_share_arb #(
        .RR_INIT (RR_INIT),
        .XLEN    (XLEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_OP_SLTU: return {31'b0, a < b};
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            default:     return 32'h0;
        endcase
    endfunction

    // External ALU stand-in.
    always_comb bus.alu_res = ref_alu(bus.alu_op, bus.alu_data1, bus.alu_data2);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one job in flight, aged in cycles since acceptance.
    bit          m_busy;
    int          m_age;
    bit          m_owner;
    logic [7:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    bit          m_prio;
    int          m_win;
    bit          cmp_en = 1'b0;

    function automatic int pick(input bit v0, input bit v1, input bit prio);
        if (v0 && v1) return int'(prio);
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    always_comb m_win = pick(bus.req0_valid, bus.req1_valid, m_prio);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_age   <= 0;
            m_owner <= 1'b0;
            m_res   <= 32'h0;
            m_prio  <= (RR_INIT != 0);
        end else if (!m_busy) begin
            if (m_win >= 0) begin
                m_busy  <= 1'b1;
                m_age   <= 1;
                m_owner <= (m_win == 1);
                m_op    <= (m_win == 1) ? bus.req1_op    : bus.req0_op;
                m_a     <= (m_win == 1) ? bus.req1_data1 : bus.req0_data1;
                m_b     <= (m_win == 1) ? bus.req1_data2 : bus.req0_data2;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
            m_res <= ref_alu(m_op, m_a, m_b);
        end else if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
            m_busy <= 1'b0;
            m_prio <= !m_owner;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req0_ready", bus.req0_ready, rst_n && !m_busy && m_win == 0);
            chk("req1_ready", bus.req1_ready, rst_n && !m_busy && m_win == 1);
            chk("alu_op", bus.alu_op, (m_busy && m_age == 1) ? m_op : 8'h0);
            chk("alu_data1", bus.alu_data1, (m_busy && m_age == 1) ? m_a : 32'h0);
            chk("alu_data2", bus.alu_data2, (m_busy && m_age == 1) ? m_b : 32'h0);
            chk("rsp0_valid", bus.rsp0_valid, m_busy && m_age >= 2 && !m_owner);
            chk("rsp1_valid", bus.rsp1_valid, m_busy && m_age >= 2 && m_owner);
            chk("rsp0_res", bus.rsp0_res, m_res);
            chk("rsp1_res", bus.rsp1_res, m_res);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.req0_valid = 1'b0; bus.req0_op = 8'h0; bus.req0_data1 = '0; bus.req0_data2 = '0;
        bus.req1_valid = 1'b0; bus.req1_op = 8'h0; bus.req1_data1 = '0; bus.req1_data2 = '0;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic set0(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_data1 = a; bus.req0_data2 = b;
    endtask

    task automatic set1(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_data1 = a; bus.req1_data2 = b;
    endtask

    initial begin
        rst_n = 1'b0;
        quiet();
        step();
        cmp_en = 1'b1;
        // Reset: outputs quiet even with a request pending.
        bus.req0_valid = 1'b1;
        #2;
        chk("rst req0_ready", bus.req0_ready, 1'b0);
        chk("rst alu_op", bus.alu_op, 8'h0);
        chk("rst rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("rst rsp_res", bus.rsp1_res, 32'h0);
        step();
        quiet();
        rst_n = 1'b1;
        step();

        // Single request: ADD 5+7 on port 0.
        set0(ALU_OP_ADD, 32'd5, 32'd7);
        #2 chk("single accept", bus.req0_ready, 1'b1);
        step();
        quiet();
        #2;
        chk("single alu_op", bus.alu_op, 8'h01);
        chk("single alu_a", bus.alu_data1, 32'd5);
        chk("single alu_b", bus.alu_data2, 32'd7);
        step();
        #2;
        chk("single rsp0_valid", bus.rsp0_valid, 1'b1);
        chk("single res", bus.rsp0_res, 32'd12);
        chk("single rsp1_valid", bus.rsp1_valid, 1'b0);
        bus.rsp0_ready = 1'b1;
        step();
        quiet();

        // Backpressure: ptr now 1, so port 1 wins SLTU 3<9 while port 0 waits.
        set1(ALU_OP_SLTU, 32'd3, 32'd9);
        set0(ALU_OP_ADD, 32'd1, 32'd1);
        #2;
        chk("bp ready1", bus.req1_ready, 1'b1);
        chk("bp ready0", bus.req0_ready, 1'b0);
        step();
        bus.req1_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("bp rsp1_valid", bus.rsp1_valid, 1'b1);
            chk("bp rsp1_res", bus.rsp1_res, 32'd1);
            chk("bp no grant", bus.req0_ready, 1'b0);
            step();
        end
        bus.rsp1_ready = 1'b1;
        step();
        quiet();
        step();

        // Contention with ptr=0: 0, 1, then 0 again.
        set0(ALU_OP_SUB, 32'd10, 32'd3);
        set1(ALU_OP_SRA, 32'h8000_0000, 32'd4);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #2 chk("cont first 0", bus.req0_ready, 1'b1);
        step();
        step();
        #2 chk("cont res0", bus.rsp0_res, 32'd7);
        step();
        #2 chk("cont then 1", bus.req1_ready, 1'b1);
        step();
        step();
        #2 chk("cont res1", bus.rsp1_res, 32'hF800_0000);
        step();
        #2 chk("cont again 0", bus.req0_ready, 1'b1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        step();
        quiet();

        // Invalid opcode still answers, with 0.
        set1(8'hff, 32'd123, 32'd456);
        step();
        bus.req1_valid = 1'b0;
        step();
        #2;
        chk("badop rsp1_valid", bus.rsp1_valid, 1'b1);
        chk("badop res", bus.rsp1_res, 32'h0);
        bus.rsp1_ready = 1'b1;
        step();
        quiet();

        // Operands changing after acceptance are ignored.
        set0(ALU_OP_ADD, 32'd100, 32'd23);
        step();
        bus.req0_valid = 1'b0;
        bus.req0_data1 = 32'd999;
        bus.req0_data2 = 32'd1;
        #2 chk("late alu_a", bus.alu_data1, 32'd100);
        step();
        #2 chk("late res", bus.rsp0_res, 32'd123);
        bus.rsp0_ready = 1'b1;
        step();
        quiet();

        // Async reset mid-EXEC (ptr is 1 here, so RR_INIT must be restored).
        set1(ALU_OP_ADD, 32'd1, 32'd2);
        step();
        quiet();
        bus.req0_valid = 1'b1;
        #2 chk("arst pre alu_op", bus.alu_op, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("arst alu_op", bus.alu_op, 8'h0);
        chk("arst alu_a", bus.alu_data1, 32'h0);
        chk("arst req0_ready", bus.req0_ready, 1'b0);
        chk("arst rsp1_valid", bus.rsp1_valid, 1'b0);
        step();
        step();
        quiet();
        rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        step();
        #2 chk("arst no rsp", bus.rsp1_valid, 1'b0);
        step();
        set0(ALU_OP_OR, 32'hf0, 32'h0f);
        set1(ALU_OP_OR, 32'h1, 32'h2);
        #2;
        chk("arst rr_init wins", bus.req0_ready, 1'b1);
        chk("arst other waits", bus.req1_ready, 1'b0);
        step();
        quiet();
        bus.rsp0_ready = 1'b1;
        step();
        step();
        quiet();

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int c = 0; c < 1500; c++) begin
            bus.req0_valid = ($urandom_range(0, 1) == 1);
            bus.req1_valid = ($urandom_range(0, 1) == 1);
            bus.req0_op    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            bus.req1_op    = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
            bus.req0_data1 = $urandom;
            bus.req0_data2 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            bus.req1_data1 = $urandom;
            bus.req1_data2 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            bus.rsp0_ready = ($urandom_range(0, 2) != 0);
            bus.rsp1_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
            step();
        end

        quiet();
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares the single combinational integer ALU between two requesters, e.g. the main execute stage (port 0) and an address/branch helper (port 1).
- Grants one request at a time using 2-way round-robin, drives the ALU from registered operands, and holds the result in a response register until the owning requester accepts it.
- Sits between the requesters and the external ALU instance. The ALU itself is not instantiated inside this block.

Parameters:
- RR_INIT, 0, requester that has priority after reset (0 or 1).
- XLEN, 32, operand/result width; must match the ALU.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  request 0 accepted this cycle.
- req0_op  in  8  ALU opcode (8'h1..8'ha; any other value is a nop).
- req0_data1  in  XLEN  operand a.
- req0_data2  in  XLEN  operand b.
- rsp0_valid  out  1  result for requester 0 is held.
- rsp0_ready  in  1  requester 0 accepts the result.
- rsp0_res  out  XLEN  result for requester 0.
- req1_valid, req1_ready, req1_op, req1_data1, req1_data2, rsp1_valid, rsp1_ready, rsp1_res: same as port 0, for requester 1.
- alu_op  out  8  opcode to the ALU.
- alu_data1  out  XLEN  operand a to the ALU.
- alu_data2  out  XLEN  operand b to the ALU.
- alu_res  in  XLEN  combinational result from the ALU.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=RR_INIT.
  - Latched op, operands, owner id and result register all cleared to 0.
  - req*_ready=0, rsp*_valid=0, rsp*_res=0.
  - alu_op/alu_data1/alu_data2 = 0 (nop).
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Exactly one of req0_ready/req1_ready is asserted, combinationally, for the winner among the valid requesters.
  - Only one requester valid: it wins regardless of ptr.
  - Both valid: requester ptr wins.
  - On a grant: latch op, data1, data2 and owner id; go to EXEC.
  - No requester valid: stay in IDLE with ready=0.
- EXEC (1 cycle):
  - alu_op/alu_data1/alu_data2 are driven from the latched registers.
  - alu_res is captured into the result register at the end of the cycle; go to RESP.
  - In every other state the ALU outputs are 0.
- RESP:
  - rsp<owner>_valid=1 and rsp<owner>_res = result register; the other port's rsp_valid stays 0.
  - Both rsp*_res buses show the result register; only the owner's valid qualifies it.
  - On rsp<owner>_ready=1: ptr := ~owner, go to IDLE.
  - Otherwise hold valid and result stable; rsp_res must not change while valid is high.
- Timing:
  - Latency from the accept cycle to rsp_valid: 2 clocks.
  - Minimum issue interval: 3 clocks (no grant in EXEC or RESP; both ready outputs are 0 there).
- Fairness: under continuous contention the grants alternate 0,1,0,1…; a requester waits at most one transaction.
- Opcode: passed through unchanged, so invalid opcodes yield alu_res=0 and still return a response.
- Widths: no arithmetic is done in this block; all data paths are XLEN bits with no extension.
- Reset during EXEC or RESP: the in-flight transaction is dropped with no response, and ptr returns to RR_INIT.
- Requester inputs are sampled only in the accept cycle; later changes have no effect on the transaction.

Decomposition:
- Shared package:
  - ALU opcode constants ALU_OP_NOP=8'h0, ADD=8'h1, SUB=8'h2, SLL=8'h3, SLT=8'h4, SLTU=8'h5, XOR=8'h6, SRL=8'h7, SRA=8'h8, OR=8'h9, AND=8'ha.
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- Sub-module rr_arb2: combinational grant from req[1:0] and ptr; one-hot gnt[1:0] plus winner id. Reusable for other 2-way shared resources.

Test Plan:
- Single request: req0 ADD 5+7 -> req0_ready in the accept cycle, alu_op=8'h1 with operands 5,7 one cycle later, rsp0_valid with res=12 two cycles after accept; rsp1_valid stays 0.
- Contention: both valid every cycle, req0 SUB 10-3, req1 SRA 0x80000000>>4, ptr=0 -> port 0 served first (res 7), then port 1 (res 0xF8000000), then port 0 again.
- Backpressure: rsp1_ready held 0 for 5 cycles with res=1 (SLTU 3<9) -> rsp1_valid and res stable; no new grant until rsp1_ready=1.
- Invalid opcode: req1 op=8'hff -> response returned with res=0 after the normal 2-clock latency.
- Async reset mid-EXEC: rst_n pulled low while in EXEC -> all outputs 0 immediately with no clock edge, no response after release, and the next contention is won by RR_INIT.
- Operand change after accept: req0_data1 changes the cycle after accept -> the result reflects the originally latched values.
